// File: rtl/alu_cmd_issuer.sv
// ALU command issuer: registers one command at a time into an external ALU.
// Results and flags are buffered in a small response FIFO.
module alu_cmd_issuer #(
  parameter int FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [31:0] cmd_a,
  input  logic [31:0] cmd_b,
  input  logic [3:0]  cmd_con,
  input  logic        cmd_chain,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  output logic [3:0]  alu_con,
  input  logic [31:0] alu_res,
  input  logic        alu_neg,
  input  logic        alu_carry,
  input  logic        alu_overflow,
  input  logic        alu_zero,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_res,
  output logic [3:0]  rsp_flags,
  output logic        sticky_ovf,
  output logic [15:0] op_count
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic {
    IDLE,
    EXEC
  } state_t;

  state_t state;
  state_t state_nx;

  logic          up;
  logic          push;
  logic          pop;
  logic          accept;
  logic          full;
  logic [AW-1:0] wptr;
  logic [AW-1:0] rptr;
  logic [CW-1:0] count;
  logic [31:0]   last_res;
  logic [35:0]   mem [FIFO_DEPTH];
  logic [35:0]   head;

  assign full      = (count == CW'(FIFO_DEPTH));
  assign rsp_valid = (count != '0);
  assign pop       = rsp_valid && rsp_ready;
  assign accept    = cmd_valid && cmd_ready;
  assign head      = mem[rptr];
  assign rsp_res   = rsp_valid ? head[35:4] : '0;
  assign rsp_flags = rsp_valid ? head[3:0] : '0;

  always_comb begin
    state_nx  = state;
    cmd_ready = 1'b0;
    push      = 1'b0;
    unique case (state)
      IDLE: begin
        cmd_ready = up && !full;
        if (cmd_valid && cmd_ready)
          state_nx = EXEC;
      end
      EXEC: begin
        push     = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // up delays cmd_ready until the first edge after reset release
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      up    <= 1'b0;
    end else begin
      state <= state_nx;
      up    <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_a   <= '0;
      alu_b   <= '0;
      alu_con <= '0;
    end else if (accept) begin
      alu_a   <= cmd_chain ? last_res : cmd_a;
      alu_b   <= cmd_b;
      alu_con <= cmd_con;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_res   <= '0;
      sticky_ovf <= 1'b0;
      op_count   <= '0;
    end else if (push) begin
      last_res <= alu_res;
      if (alu_overflow)
        sticky_ovf <= 1'b1;
      if (op_count != 16'hFFFF)
        op_count <= op_count + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (push)
      mem[wptr] <= {alu_res, alu_neg, alu_carry, alu_overflow, alu_zero};
  end

  // power-of-two depth lets the pointers wrap by plain overflow
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push)
        wptr <= wptr + AW'(1);
      if (pop)
        rptr <= rptr + AW'(1);
      unique case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_cmd_issuer.sv
// Bench for alu_cmd_issuer with a behavioural 32-bit ALU.
// Expected responses queue on accept and are checked on each pop.
module tb_alu_cmd_issuer;

  logic        clk;
  logic        rst_n;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [31:0] cmd_a;
  logic [31:0] cmd_b;
  logic [3:0]  cmd_con;
  logic        cmd_chain;
  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic [3:0]  alu_con;
  logic [35:0] alu_o;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_res;
  logic [3:0]  rsp_flags;
  logic        sticky_ovf;
  logic [15:0] op_count;

  int n_cmp;
  int n_bad;
  int n_ops;
  logic [35:0] sb[$];

  function automatic logic [35:0] alu_fn(
    input logic [31:0] a,
    input logic [31:0] b,
    input logic [3:0]  c
  );
    logic [32:0] s;
    logic [31:0] r;
    logic        cy;
    logic        ov;
    s  = '0;
    cy = 1'b0;
    ov = 1'b0;
    case (c)
      4'd0: begin
        s  = {1'b0, a} + {1'b0, b};
        r  = s[31:0];
        cy = s[32];
        ov = (a[31] == b[31]) && (r[31] != a[31]);
      end
      4'd1: begin
        s  = {1'b0, a} + {1'b0, ~b} + 33'd1;
        r  = s[31:0];
        cy = s[32];
        ov = (a[31] != b[31]) && (r[31] != a[31]);
      end
      4'd2:    r = a & b;
      4'd3:    r = a | b;
      default: r = a ^ b;
    endcase
    return {r, r[31], cy, ov, (r == 32'd0)};
  endfunction

  assign alu_o = alu_fn(alu_a, alu_b, alu_con);

  alu_cmd_issuer #(.FIFO_DEPTH(2)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .cmd_valid    (cmd_valid),
    .cmd_ready    (cmd_ready),
    .cmd_a        (cmd_a),
    .cmd_b        (cmd_b),
    .cmd_con      (cmd_con),
    .cmd_chain    (cmd_chain),
    .alu_a        (alu_a),
    .alu_b        (alu_b),
    .alu_con      (alu_con),
    .alu_res      (alu_o[35:4]),
    .alu_neg      (alu_o[3]),
    .alu_carry    (alu_o[2]),
    .alu_overflow (alu_o[1]),
    .alu_zero     (alu_o[0]),
    .rsp_valid    (rsp_valid),
    .rsp_ready    (rsp_ready),
    .rsp_res      (rsp_res),
    .rsp_flags    (rsp_flags),
    .sticky_ovf   (sticky_ovf),
    .op_count     (op_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && rsp_valid && rsp_ready) begin
      if (sb.size() == 0) begin
        chk("unexpected_rsp", 32'd1, 32'd0);
      end else begin
        logic [35:0] e;
        e = sb.pop_front();
        chk("rsp_res", rsp_res, e[35:4]);
        chk("rsp_flags", {28'd0, rsp_flags}, {28'd0, e[3:0]});
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [31:0] a, input logic [31:0] b,
                       input logic [3:0] con, input logic chain);
    cmd_valid = 1'b1;
    cmd_a     = a;
    cmd_b     = b;
    cmd_con   = con;
    cmd_chain = chain;
  endtask

  // returns at 1 time unit after the accepting edge (DUT then in EXEC)
  task automatic wait_acc(input bit track, input logic [31:0] er,
                          input logic [3:0] ef);
    int  i;
    bit  got;
    i   = 0;
    got = 1'b0;
    @(negedge clk);
    while (!cmd_ready && i < 50) begin
      @(negedge clk);
      i++;
    end
    got = cmd_ready;
    tick(1);
    cmd_valid = 1'b0;
    cmd_chain = 1'b0;
    chk("accepted", {31'd0, got}, 32'd1);
    if (got) begin
      n_ops++;
      if (track)
        sb.push_back({er, ef});
    end
  endtask

  task automatic issue(input logic [31:0] a, input logic [31:0] b,
                       input logic [3:0] con, input logic chain,
                       input bit track, input logic [31:0] er,
                       input logic [3:0] ef);
    drive(a, b, con, chain);
    wait_acc(track, er, ef);
  endtask

  task automatic drain();
    int i;
    i = 0;
    while (sb.size() != 0 && i < 100) begin
      tick(1);
      i++;
    end
    chk("drain_left", sb.size(), 32'd0);
  endtask

  initial begin
    logic [31:0] ra;
    logic [31:0] rb;
    logic [3:0]  rc;
    logic [35:0] ex;
    n_cmp     = 0;
    n_bad     = 0;
    n_ops     = 0;
    rst_n     = 1'b0;
    cmd_valid = 1'b0;
    cmd_a     = '0;
    cmd_b     = '0;
    cmd_con   = '0;
    cmd_chain = 1'b0;
    rsp_ready = 1'b0;

    tick(2);
    chk("rst_cmd_ready", {31'd0, cmd_ready}, 32'd0);
    chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("rst_rsp_res", rsp_res, 32'd0);
    chk("rst_alu_a", alu_a, 32'd0);
    chk("rst_sticky", {31'd0, sticky_ovf}, 32'd0);
    chk("rst_op_count", {16'd0, op_count}, 32'd0);
    rst_n = 1'b1;
    #1;
    chk("ready_before_edge", {31'd0, cmd_ready}, 32'd0);
    tick(1);
    chk("ready_after_edge", {31'd0, cmd_ready}, 32'd1);

    // single add, response buffered one edge after accept
    rsp_ready = 1'b1;
    issue(32'd5, 32'd3, 4'd0, 1'b0, 1'b1, 32'd8, 4'b0000);
    chk("exec_alu_a", alu_a, 32'd5);
    chk("exec_alu_b", alu_b, 32'd3);
    chk("exec_ready", {31'd0, cmd_ready}, 32'd0);
    chk("exec_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    tick(1);
    chk("lat_rsp_valid", {31'd0, rsp_valid}, 32'd1);
    chk("op_count_1", {16'd0, op_count}, 32'd1);
    tick(3);
    chk("hold_alu_a", alu_a, 32'd5);
    chk("drained_valid", {31'd0, rsp_valid}, 32'd0);

    // signed overflow
    issue(32'h7FFFFFFF, 32'h7FFFFFFF, 4'd0, 1'b0, 1'b1,
          32'hFFFFFFFE, 4'b1010);
    tick(1);
    chk("sticky_set", {31'd0, sticky_ovf}, 32'd1);
    issue(32'd1, 32'd1, 4'd0, 1'b0, 1'b1, 32'd2, 4'b0000);
    tick(2);
    chk("sticky_held", {31'd0, sticky_ovf}, 32'd1);

    // chained operand
    issue(32'd5, 32'd3, 4'd0, 1'b0, 1'b1, 32'd8, 4'b0000);
    tick(1);
    issue(32'hDEADBEEF, 32'hFFFFFFF8, 4'd0, 1'b1, 1'b1,
          32'd0, 4'b0101);
    chk("chain_alu_a", alu_a, 32'd8);
    drain();

    // backpressure: two fill the buffer, third must wait
    rsp_ready = 1'b0;
    issue(32'd10, 32'd20, 4'd0, 1'b0, 1'b1, 32'd30, 4'b0000);
    tick(1);
    issue(32'd100, 32'd1, 4'd1, 1'b0, 1'b1, 32'd99, 4'b0100);
    tick(1);
    drive(32'd1, 32'd2, 4'd0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("full_ready", {31'd0, cmd_ready}, 32'd0);
      chk("stable_res", rsp_res, 32'd30);
    end
    tick(1);
    rsp_ready = 1'b1;
    wait_acc(1'b1, 32'd3, 4'b0000);
    drain();

    // each push lands on the same edge as the previous entry's pop
    for (int i = 0; i < 8; i++) begin
      ra = $urandom;
      rb = $urandom;
      rc = 4'($urandom_range(0, 3));
      ex = alu_fn(ra, rb, rc);
      rsp_ready = 1'b0;
      issue(ra, rb, rc, 1'b0, 1'b1, ex[35:4], ex[3:0]);
      rsp_ready = 1'b1;
      tick(1);
      chk("overlap_valid", {31'd0, rsp_valid}, 32'd1);
    end
    drain();
    tick(2);
    chk("op_count_total", {16'd0, op_count}, n_ops);

    // reset while EXEC discards the command
    issue(32'd9, 32'd9, 4'd0, 1'b0, 1'b0, 32'd0, 4'b0000);
    rst_n = 1'b0;
    #1;
    chk("rst2_ready", {31'd0, cmd_ready}, 32'd0);
    chk("rst2_alu_a", alu_a, 32'd0);
    chk("rst2_alu_b", alu_b, 32'd0);
    chk("rst2_alu_con", {28'd0, alu_con}, 32'd0);
    chk("rst2_valid", {31'd0, rsp_valid}, 32'd0);
    chk("rst2_flags", {28'd0, rsp_flags}, 32'd0);
    chk("rst2_sticky", {31'd0, sticky_ovf}, 32'd0);
    chk("rst2_op_count", {16'd0, op_count}, 32'd0);
    tick(2);
    rst_n = 1'b1;
    n_ops = 0;
    tick(5);
    chk("post_rst_valid", {31'd0, rsp_valid}, 32'd0);
    chk("post_rst_count", {16'd0, op_count}, 32'd0);

    // chain with no prior result uses zero
    issue(32'd123, 32'd7, 4'd0, 1'b1, 1'b1, 32'd7, 4'b0000);
    drain();
    tick(1);
    chk("final_op_count", {16'd0, op_count}, n_ops);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
